// File: rtl/btn_event_gen_pkg.sv
// Shared definitions for the button event generator: FSM state encodings and width helpers.
package btn_event_gen_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t ST_IDLE   = 2'd0;
    localparam btn_state_t ST_HELD   = 2'd1;
    localparam btn_state_t ST_REPEAT = 2'd2;

    // Never returns zero, so single-value counters still get a legal width.
    function automatic int unsigned safe_clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_evt_fsm.sv
// Per-button press/hold/repeat FSM; produces combinational press and release strobes.
module btn_evt_fsm
    import btn_event_gen_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned CNT_W        = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic lvl,
    input  logic prev,
    input  logic tick,
    input  logic rpt_en,
    input  logic masked,
    output logic evt_i,
    output logic rel_i
);

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_count;

    assign w_rise  = lvl & ~prev;
    assign w_fall  = ~lvl & prev;
    assign w_count = tick & rpt_en;

    // Release is checked first so it beats a repeat firing on the same tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        evt_i       = 1'b0;
        rel_i       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    evt_i       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    rel_i       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (masked && w_count) begin
                    if (r_cnt == CNT_W'(HOLD_TICKS - 1)) begin
                        evt_i       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (w_fall) begin
                    rel_i       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_count) begin
                    if (r_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
                        evt_i     = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Turns debounced button levels into registered press/release/repeat pulses plus an encoded code.
module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int unsigned      N_BTN        = 9,
    parameter int unsigned      TICK_DIV     = 1001,
    parameter int unsigned      HOLD_TICKS   = 500,
    parameter int unsigned      REPEAT_TICKS = 100,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = N_BTN'('h003)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_lvl,
    output logic [N_BTN-1:0]         evt,
    output logic [N_BTN-1:0]         rel,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_code
);

    localparam int unsigned TICK_W = safe_clog2(TICK_DIV);
    localparam int unsigned CNT_W  = safe_clog2(max_u(HOLD_TICKS, REPEAT_TICKS) + 1);
    localparam int unsigned CODE_W = $clog2(N_BTN);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [N_BTN-1:0]  r_prev;
    logic [N_BTN-1:0]  w_masked;
    logic              w_rpt_en;
    logic [N_BTN-1:0]  w_evt;
    logic [N_BTN-1:0]  w_rel;
    logic [CODE_W-1:0] w_code;
    logic [N_BTN-1:0]  r_evt;
    logic [N_BTN-1:0]  r_rel;
    logic              r_valid;
    logic [CODE_W-1:0] r_code;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    // More than one masked button high (x & (x-1) != 0) inhibits repeats.
    assign w_masked = btn_lvl & REPEAT_MASK;
    assign w_rpt_en = ~|(w_masked & (w_masked - N_BTN'(1)));

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_evt_fsm #(
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .CNT_W        (CNT_W)
        ) u_fsm (
            .clk    (clk),
            .reset  (reset),
            .lvl    (btn_lvl[g]),
            .prev   (r_prev[g]),
            .tick   (w_tick),
            .rpt_en (w_rpt_en),
            .masked (REPEAT_MASK[g]),
            .evt_i  (w_evt[g]),
            .rel_i  (w_rel[g])
        );
    end

    always_comb begin
        w_code = '0;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (w_evt[i]) begin
                w_code = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_prev     <= '0;
            r_evt      <= '0;
            r_rel      <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            r_prev     <= btn_lvl;
            r_evt      <= w_evt;
            r_rel      <= w_rel;
            r_valid    <= |w_evt;
            r_code     <= w_code;
        end
    end

    assign evt       = r_evt;
    assign rel       = r_rel;
    assign evt_valid = r_valid;
    assign evt_code  = r_code;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2.
module tb_btn_event_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] btn_lvl;
    logic [8:0] evt;
    logic [8:0] rel;
    logic       evt_valid;
    logic [3:0] evt_code;

    int n_assert = 0;
    int n_fail   = 0;

    btn_event_gen #(
        .N_BTN        (9),
        .TICK_DIV     (4),
        .HOLD_TICKS   (3),
        .REPEAT_TICKS (2),
        .REPEAT_MASK  (9'h003)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_lvl   (btn_lvl),
        .evt       (evt),
        .rel       (rel),
        .evt_valid (evt_valid),
        .evt_code  (evt_code)
    );

    always #5 clk = ~clk;

    task automatic chk_now(input logic [8:0] ee, input logic [8:0] er, input logic [3:0] ec,
                           input string tag, input int e);
        n_assert++;
        assert (evt === ee) else begin
            n_fail++;
            $error("FAIL %s@E%0d evt got %h want %h", tag, e, evt, ee);
        end
        n_assert++;
        assert (rel === er) else begin
            n_fail++;
            $error("FAIL %s@E%0d rel got %h want %h", tag, e, rel, er);
        end
        n_assert++;
        assert (evt_valid === (|ee)) else begin
            n_fail++;
            $error("FAIL %s@E%0d evt_valid got %b want %b", tag, e, evt_valid, |ee);
        end
        n_assert++;
        assert (evt_code === ec) else begin
            n_fail++;
            $error("FAIL %s@E%0d evt_code got %0d want %0d", tag, e, evt_code, ec);
        end
    endtask

    // One active edge with the current inputs, then check the registered outputs.
    task automatic step_chk(input logic [8:0] ee, input logic [8:0] er, input logic [3:0] ec,
                            input string tag, input int e);
        @(posedge clk);
        #1;
        chk_now(ee, er, ec, tag, e);
    endtask

    // Reset released mid-cycle, so the next edge is E1 and ticks fall on E4, E8, E12, ...
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_now(9'h000, 9'h000, 4'd0, tag, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_now(9'h000, 9'h000, 4'd0, tag, 0);
        #3 reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        btn_lvl = 9'h000;
        #2;
        do_reset("reset");

        // 1: async reset while bit0 is in REPEAT, then one press evt after release
        btn_lvl = 9'h001;
        step_chk(9'h001, 9'h000, 4'd0, "t1_press", 1);
        for (int e = 2; e <= 11; e++) step_chk(9'h000, 9'h000, 4'd0, "t1_hold", e);
        step_chk(9'h001, 9'h000, 4'd0, "t1_rpt", 12);
        do_reset("t1_async");
        step_chk(9'h001, 9'h000, 4'd0, "t1_repress", 1);
        for (int e = 2; e <= 8; e++) step_chk(9'h000, 9'h000, 4'd0, "t1_quiet", e);
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h001, 4'd0, "t1_rel", 9);

        // 2: short press on unmasked bit4
        do_reset("t2_rst");
        btn_lvl = 9'h010;
        step_chk(9'h010, 9'h000, 4'd4, "t2_press", 1);
        for (int e = 2; e <= 5; e++) step_chk(9'h000, 9'h000, 4'd0, "t2_hold", e);
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h010, 4'd0, "t2_rel", 6);
        step_chk(9'h000, 9'h000, 4'd0, "t2_idle", 7);

        // 3: bit0 held 60 cycles: press E1, first repeat E12, then every 8 cycles
        do_reset("t3_rst");
        btn_lvl = 9'h001;
        for (int e = 1; e <= 60; e++) begin
            if (e == 1 || (e >= 12 && (e - 12) % 8 == 0))
                step_chk(9'h001, 9'h000, 4'd0, "t3_evt", e);
            else
                step_chk(9'h000, 9'h000, 4'd0, "t3_quiet", e);
        end
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h001, 4'd0, "t3_rel", 61);
        step_chk(9'h000, 9'h000, 4'd0, "t3_idle", 62);

        // 4: unmasked bit4 held 60 cycles: a single press, no repeats
        do_reset("t4_rst");
        btn_lvl = 9'h010;
        step_chk(9'h010, 9'h000, 4'd4, "t4_press", 1);
        for (int e = 2; e <= 60; e++) step_chk(9'h000, 9'h000, 4'd0, "t4_hold", e);
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h010, 4'd0, "t4_rel", 61);
        step_chk(9'h000, 9'h000, 4'd0, "t4_idle", 62);

        // 5: bits 0 and 1 together inhibit repeats; dropping bit1 resumes bit0
        do_reset("t5_rst");
        btn_lvl = 9'h003;
        step_chk(9'h003, 9'h000, 4'd0, "t5_press", 1);
        for (int e = 2; e <= 20; e++) step_chk(9'h000, 9'h000, 4'd0, "t5_inhib", e);
        btn_lvl = 9'h001;
        step_chk(9'h000, 9'h002, 4'd0, "t5_rel1", 21);
        for (int e = 22; e <= 31; e++) step_chk(9'h000, 9'h000, 4'd0, "t5_count", e);
        step_chk(9'h001, 9'h000, 4'd0, "t5_rpt", 32);
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h001, 4'd0, "t5_rel0", 33);

        // 5b: bit0 reaches count 2, bit1 freezes it, the count survives the inhibit
        do_reset("t5b_rst");
        btn_lvl = 9'h001;
        step_chk(9'h001, 9'h000, 4'd0, "t5b_press0", 1);
        for (int e = 2; e <= 8; e++) step_chk(9'h000, 9'h000, 4'd0, "t5b_count", e);
        btn_lvl = 9'h003;
        step_chk(9'h002, 9'h000, 4'd1, "t5b_press1", 9);
        for (int e = 10; e <= 20; e++) step_chk(9'h000, 9'h000, 4'd0, "t5b_frozen", e);
        btn_lvl = 9'h001;
        step_chk(9'h000, 9'h002, 4'd0, "t5b_rel1", 21);
        step_chk(9'h000, 9'h000, 4'd0, "t5b_wait", 22);
        step_chk(9'h000, 9'h000, 4'd0, "t5b_wait", 23);
        step_chk(9'h001, 9'h000, 4'd0, "t5b_resume", 24);
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h001, 4'd0, "t5b_rel0", 25);

        // 6: release on the same edge as a repeat firing: release wins
        do_reset("t6_rst");
        btn_lvl = 9'h001;
        for (int e = 1; e <= 19; e++) begin
            if (e == 1 || e == 12)
                step_chk(9'h001, 9'h000, 4'd0, "t6_evt", e);
            else
                step_chk(9'h000, 9'h000, 4'd0, "t6_quiet", e);
        end
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h001, 4'd0, "t6_relwins", 20);
        step_chk(9'h000, 9'h000, 4'd0, "t6_idle", 21);

        // 7: simultaneous rises, and release plus rise on different buttons
        do_reset("t7_rst");
        btn_lvl = 9'h090;
        step_chk(9'h090, 9'h000, 4'd4, "t7_dual", 1);
        step_chk(9'h000, 9'h000, 4'd0, "t7_hold", 2);
        btn_lvl = 9'h084;
        step_chk(9'h004, 9'h010, 4'd2, "t7_swap", 3);
        step_chk(9'h000, 9'h000, 4'd0, "t7_hold", 4);
        btn_lvl = 9'h000;
        step_chk(9'h000, 9'h084, 4'd0, "t7_rel", 5);
        step_chk(9'h000, 9'h000, 4'd0, "t7_idle", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
